// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 burst types, page size and size decode helper
package axi4_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_e;

   localparam int PAGE_BYTES = 4096;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_e;

   function automatic logic [7:0] size_bytes(input logic [2:0] size);
      return 8'd1 << size;
   endfunction

endpackage

// File: rtl/axi4_beat_strb_gen.sv
// rtl/axi4_beat_strb_gen.sv - combinational byte-lane strobe for one beat from (addr, size)
module axi4_beat_strb_gen
   import axi4_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 32
) (
   input  logic [ADDRESS_WIDTH-1:0]  addr,
   input  logic [2:0]                size,
   output logic [DATA_WIDTH/8-1:0]   strb
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int SW = ADDRESS_WIDTH + 1;

   logic [SW-1:0] b_w;
   logic [SW-1:0] a0_w;
   logic [SW-1:0] lo_w;
   logic [SW-1:0] hi_w;

   // Lanes run from the start byte up to the end of the size-aligned container;
   // lanes past the bus width simply never match.
   always_comb begin
      b_w  = SW'(size_bytes(size));
      a0_w = {1'b0, addr} & ~(b_w - SW'(1));
      lo_w = {1'b0, addr} & SW'(NB - 1);
      hi_w = (a0_w & SW'(NB - 1)) + b_w - SW'(1);
      strb = '0;
      for (int i = 0; i < NB; i++) begin
         strb[i] = (SW'(i) >= lo_w) && (SW'(i) <= hi_w);
      end
   end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// rtl/axi4_burst_addr_gen.sv - per-burst AXI4 address/strobe/index sequencer
// WRAP is sequenced only when AXI_BURST_WRAP_EN is defined; otherwise it is an illegal burst.
module axi4_burst_addr_gen
   import axi4_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 32,
   parameter int ID_WIDTH      = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ID_WIDTH-1:0]       cmd_id,
   input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
   input  logic [7:0]                cmd_len,
   input  logic [2:0]                cmd_size,
   input  logic [1:0]                cmd_burst,
   output logic                      beat_valid,
   input  logic                      beat_ready,
   output logic [ID_WIDTH-1:0]       beat_id,
   output logic [ADDRESS_WIDTH-1:0]  beat_addr,
   output logic [DATA_WIDTH/8-1:0]   beat_strb,
   output logic [7:0]                beat_idx,
   output logic                      beat_last,
   output logic                      beat_err,
   output logic                      four_4Kb_violation
);
   localparam int NB     = DATA_WIDTH / 8;
   localparam int LOG2NB = $clog2(NB);
   localparam int AW     = ADDRESS_WIDTH;

   state_e              state_q, state_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          idx_q, idx_d;
   logic [2:0]          size_q, size_d;
   burst_e              mode_q, mode_d;
   logic                err_q, err_d;
   logic                viol_q, viol_d;

`ifdef AXI_BURST_WRAP_EN
   logic [AW-1:0]       wrap_base_q, wrap_base_d;
   logic [AW:0]         wrap_end_q, wrap_end_d;
   logic [AW-1:0]       cmd_wrap_t;
   logic [AW-1:0]       cmd_wrap_base;
   logic                cmd_wrap_len_ok;
   logic [AW:0]         wrap_nxt;
`endif

   logic [7:0]          cmd_b;
   logic [7:0]          cur_b;
   logic [11:0]         cmd_a0_lo;
   logic [16:0]         page_end;
   logic                cmd_err;
   logic                cmd_viol;
   logic [AW-1:0]       next_addr;
   logic                last;
   logic [NB-1:0]       strb_raw;

   // Legality and page-crossing are judged once, on the command as presented.
   always_comb begin
      cmd_b     = size_bytes(cmd_size);
      cmd_a0_lo = cmd_addr[11:0] & ~(12'(cmd_b) - 12'd1);
      page_end  = 17'(cmd_a0_lo) + (17'({1'b0, cmd_len} + 9'd1) << cmd_size);
      cmd_viol  = (cmd_burst == BURST_INCR) && (page_end > 17'(PAGE_BYTES));
      cmd_err   = (cmd_size > 3'(LOG2NB)) || (cmd_burst == BURST_RSVD);
`ifdef AXI_BURST_WRAP_EN
      cmd_wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                        (cmd_len == 8'd7) || (cmd_len == 8'd15);
      cmd_wrap_t      = AW'({1'b0, cmd_len} + 9'd1) << cmd_size;
      cmd_wrap_base   = cmd_addr & ~(cmd_wrap_t - AW'(1));
      cmd_err = cmd_err || ((cmd_burst == BURST_WRAP) &&
                (!cmd_wrap_len_ok || ((cmd_addr & (AW'(cmd_b) - AW'(1))) != '0)));
`else
      cmd_err = cmd_err || (cmd_burst == BURST_WRAP);
`endif
   end

   always_comb begin
      cur_b     = size_bytes(size_q);
      next_addr = (addr_q & ~(AW'(cur_b) - AW'(1))) + AW'(cur_b);
`ifdef AXI_BURST_WRAP_EN
      wrap_nxt = {1'b0, addr_q} + {1'b0, AW'(cur_b)};
      if (mode_q == BURST_WRAP) begin
         next_addr = (wrap_nxt == wrap_end_q) ? wrap_base_q : wrap_nxt[AW-1:0];
      end
`endif
      if (mode_q == BURST_FIXED) begin
         next_addr = addr_q;
      end
   end

   assign last = (idx_q == len_q);

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      addr_d  = addr_q;
      len_d   = len_q;
      idx_d   = idx_q;
      size_d  = size_q;
      mode_d  = mode_q;
      err_d   = err_q;
      viol_d  = viol_q;
`ifdef AXI_BURST_WRAP_EN
      wrap_base_d = wrap_base_q;
      wrap_end_d  = wrap_end_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_BURST;
               id_d    = cmd_id;
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               idx_d   = 8'd0;
               size_d  = cmd_size;
               mode_d  = cmd_err ? BURST_INCR : burst_e'(cmd_burst);
               err_d   = cmd_err;
               viol_d  = cmd_viol;
`ifdef AXI_BURST_WRAP_EN
               wrap_base_d = cmd_wrap_base;
               wrap_end_d  = {1'b0, cmd_wrap_base} + {1'b0, cmd_wrap_t};
`endif
            end
         end
         ST_BURST: begin
            if (beat_ready) begin
               if (last) begin
                  state_d = ST_IDLE;
               end else begin
                  addr_d = next_addr;
                  idx_d  = idx_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         size_q  <= '0;
         mode_q  <= BURST_FIXED;
         err_q   <= 1'b0;
         viol_q  <= 1'b0;
`ifdef AXI_BURST_WRAP_EN
         wrap_base_q <= '0;
         wrap_end_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         size_q  <= size_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         viol_q  <= viol_d;
`ifdef AXI_BURST_WRAP_EN
         wrap_base_q <= wrap_base_d;
         wrap_end_q  <= wrap_end_d;
`endif
      end
   end

   axi4_beat_strb_gen #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_strb (
      .addr (addr_q),
      .size (size_q),
      .strb (strb_raw)
   );

   assign cmd_ready          = (state_q == ST_IDLE);
   assign beat_valid         = (state_q == ST_BURST);
   assign beat_id            = id_q;
   assign beat_addr          = addr_q;
   assign beat_idx           = idx_q;
   assign beat_last          = beat_valid && last;
   assign beat_strb          = beat_valid ? strb_raw : '0;
   assign beat_err           = err_q;
   assign four_4Kb_violation = viol_q;

endmodule
